// File: rtl/c3lib_ckdiv_pkg.sv
// Shared types and helpers for the programmable ctn clock divider family.
// The ratio clamp is kept here so every divider variant agrees on the minimum legal ratio.
package c3lib_ckdiv_pkg;

    typedef enum logic [1:0] {
        CKDIV_IDLE = 2'd0,
        CKDIV_RUN  = 2'd1,
        CKDIV_STOP = 2'd2
    } ckdiv_state_t;

    localparam int CKDIV_MIN_RATIO = 2;

    // Ratios below the minimum would degenerate into a clk_in bypass, so they are raised to it.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < 32'(CKDIV_MIN_RATIO)) ? 32'(CKDIV_MIN_RATIO) : ratio;
    endfunction

endpackage

// File: rtl/c3lib_ckdiv_cnt_ctn.sv
// Wrapping period counter for the programmable divider: tracks the position inside the
// current period and predicts where the next cycle lands relative to the half point.
module c3lib_ckdiv_cnt_ctn
    import c3lib_ckdiv_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_ratio,
    input  logic [CNT_WIDTH-1:0] i_nextRatio,
    output logic                 o_wrap,
    output logic                 o_nextZero,
    output logic                 o_nextActive
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cntNext;

    assign o_wrap    = i_run && (r_cnt == (i_ratio - CNT_WIDTH'(1)));
    assign w_cntNext = (!i_run || o_wrap) ? '0 : r_cnt + CNT_WIDTH'(1);

    // The half point is taken from the ratio that will govern the next cycle, so a ratio
    // committed at the wrap already shapes the first cycle of the new period.
    assign o_nextZero   = (w_cntNext == '0);
    assign o_nextActive = (w_cntNext < (i_nextRatio >> 1));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cntNext;
        end
    end

endmodule

// File: rtl/c3lib_ckdiv_prog_ctn.sv
// Programmable integer clock divider: clk_out = clk_in / N from a single registered flop,
// with glitch-free ratio change at period boundaries and clean stop/start.
module c3lib_ckdiv_prog_ctn
    import c3lib_ckdiv_pkg::*;
#(
    parameter int CNT_WIDTH   = 8,
    parameter int RESET_VAL   = 0,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 div_en,
    input  logic [CNT_WIDTH-1:0] div_ratio,
    input  logic                 div_load_req,
    output logic                 div_load_ack,
    output logic                 clk_out,
    output logic                 div_active,
    output logic                 period_start
);

    localparam logic                 IDLE_LVL      = (RESET_VAL != 0);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_RATIO = CNT_WIDTH'(clamp_ratio(32'(DEFAULT_DIV)));

    ckdiv_state_t         r_state;
    ckdiv_state_t         w_stateNext;
    logic [CNT_WIDTH-1:0] r_ratio;
    logic [CNT_WIDTH-1:0] w_ratioReq;
    logic [CNT_WIDTH-1:0] w_nextRatio;
    logic                 r_ackDone;
    logic                 r_clkOut;
    logic                 r_periodStart;
    logic                 w_running;
    logic                 w_nextRunning;
    logic                 w_wrap;
    logic                 w_nextZero;
    logic                 w_nextActive;
    logic                 w_commit;

    assign w_ratioReq = CNT_WIDTH'(clamp_ratio(32'(div_ratio)));
    assign w_running  = (r_state != CKDIV_IDLE);

    // A request commits at most once until the requester has been seen dropping it.
    assign w_commit    = !rst && div_load_req && !r_ackDone && (!w_running || w_wrap);
    assign w_nextRatio = w_commit ? w_ratioReq : r_ratio;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            CKDIV_IDLE: begin
                if (div_en) w_stateNext = CKDIV_RUN;
            end
            CKDIV_RUN, CKDIV_STOP: begin
                if (div_en)      w_stateNext = CKDIV_RUN;
                else if (w_wrap) w_stateNext = CKDIV_IDLE;
                else             w_stateNext = CKDIV_STOP;
            end
            default: w_stateNext = CKDIV_IDLE;
        endcase
    end

    assign w_nextRunning = (w_stateNext != CKDIV_IDLE);

    c3lib_ckdiv_cnt_ctn #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk_in       (clk_in),
        .rst          (rst),
        .i_run        (w_running),
        .i_ratio      (r_ratio),
        .i_nextRatio  (w_nextRatio),
        .o_wrap       (w_wrap),
        .o_nextZero   (w_nextZero),
        .o_nextActive (w_nextActive)
    );

    // clk_out is computed from the next counter position so it changes exactly on the edge
    // that enters each phase; leaving RUN/STOP at the wrap keeps it parked at the idle level.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= CKDIV_IDLE;
            r_ratio       <= DEFAULT_RATIO;
            r_ackDone     <= 1'b0;
            r_clkOut      <= IDLE_LVL;
            r_periodStart <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ratio <= w_nextRatio;
            if (w_commit) begin
                r_ackDone <= 1'b1;
            end else if (!div_load_req) begin
                r_ackDone <= 1'b0;
            end
            r_clkOut      <= (w_nextRunning && w_nextActive) ? ~IDLE_LVL : IDLE_LVL;
            r_periodStart <= w_nextRunning && w_nextZero;
        end
    end

    assign div_load_ack = w_commit;
    assign clk_out      = r_clkOut;
    assign period_start = r_periodStart;
    assign div_active   = w_running;

endmodule

// File: tb/tb_c3lib_ckdiv_prog_ctn.sv
// Bench for the programmable divider: two instances (idle-low and idle-high) share stimulus;
// a period-position reference model feeds a scoreboard queue drained by a separate monitor.
module tb_c3lib_ckdiv_prog_ctn;

    typedef struct packed {
        logic ack;
        logic clk;
        logic ps;
        logic act;
    } expect_t;

    logic       clk_in;
    logic       rst;
    logic       div_en;
    logic [7:0] div_ratio;
    logic       div_load_req;
    logic       ack0, clkOut0, active0, pStart0;
    logic       ack1, clkOut1, active1, pStart1;

    expect_t    sbQ[$];
    expect_t    monEx;
    int         checkCount = 0;
    int         errorCount = 0;

    bit         mRunning = 0;
    int         mPos = 0;
    int         mN = 4;
    bit         mArmed = 1;
    bit         lastAck = 0;

    c3lib_ckdiv_prog_ctn #(.CNT_WIDTH(8), .RESET_VAL(0), .DEFAULT_DIV(4)) dut0 (
        .clk_in       (clk_in),
        .rst          (rst),
        .div_en       (div_en),
        .div_ratio    (div_ratio),
        .div_load_req (div_load_req),
        .div_load_ack (ack0),
        .clk_out      (clkOut0),
        .div_active   (active0),
        .period_start (pStart0)
    );

    c3lib_ckdiv_prog_ctn #(.CNT_WIDTH(8), .RESET_VAL(1), .DEFAULT_DIV(4)) dut1 (
        .clk_in       (clk_in),
        .rst          (rst),
        .div_en       (div_en),
        .div_ratio    (div_ratio),
        .div_load_req (div_load_req),
        .div_load_ack (ack1),
        .clk_out      (clkOut1),
        .div_active   (active1),
        .period_start (pStart1)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, actual, expected, $time);
        end
    endtask

    // Model view: a period is mN cycles at positions 0..mN-1, the first floor(mN/2) are active.
    task automatic applyStimulus(input logic r, input logic e, input logic q, input logic [7:0] ra);
        expect_t ex;
        int      newN;
        @(negedge clk_in);
        rst          = r;
        div_en       = e;
        div_load_req = q;
        div_ratio    = ra;
        newN   = (ra < 2) ? 2 : int'(ra);
        ex.ack = !r && q && mArmed && (!mRunning || mPos == mN - 1);
        lastAck = ex.ack;
        if (r) begin
            mRunning = 0;
            mPos     = 0;
            mN       = 4;
            mArmed   = 1;
        end else begin
            if (!mRunning) begin
                if (ex.ack) mN = newN;
                if (e) begin
                    mRunning = 1;
                    mPos     = 0;
                end
            end else if (mPos == mN - 1) begin
                if (ex.ack) mN = newN;
                mPos     = 0;
                mRunning = e;
            end else begin
                mPos++;
            end
            if (ex.ack) mArmed = 0;
            else if (!q) mArmed = 1;
        end
        ex.act = mRunning;
        ex.ps  = mRunning && (mPos == 0);
        ex.clk = mRunning && (mPos < mN / 2);
        sbQ.push_back(ex);
    endtask

    task automatic runCycles(input int n, input logic e);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, e, 1'b0, 8'd0);
    endtask

    task automatic requestLoad(input logic [7:0] ra, input logic e);
        int n = 0;
        do begin
            applyStimulus(1'b0, e, 1'b1, ra);
            n++;
        end while (!lastAck && n < 400);
        if (!lastAck) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL loadTimeout actual=no_ack required=ack ratio=%0d", ra);
        end
        applyStimulus(1'b0, e, 1'b0, ra);
    endtask

    task automatic runToPeriodStart(input logic e);
        int n = 0;
        while (!(mRunning && mPos == 0) && n < 400) begin
            applyStimulus(1'b0, e, 1'b0, 8'd0);
            n++;
        end
    endtask

    // The monitor pairs each queued expectation with the cycle it was issued for.
    initial begin : monitor
        forever begin
            @(negedge clk_in);
            #2;
            if (sbQ.size() != 0) begin
                monEx = sbQ.pop_front();
                checkOutput("ack0", ack0, monEx.ack);
                checkOutput("ack1", ack1, monEx.ack);
                @(posedge clk_in);
                #1;
                checkOutput("clkOut0", clkOut0, monEx.clk);
                checkOutput("clkOut1", clkOut1, !monEx.clk);
                checkOutput("periodStart0", pStart0, monEx.ps);
                checkOutput("periodStart1", pStart1, monEx.ps);
                checkOutput("divActive0", active0, monEx.act);
                checkOutput("divActive1", active1, monEx.act);
            end
        end
    end

    initial begin : stimulus
        logic       rr;
        logic       en;
        logic       req;
        logic       dropNext;
        logic [7:0] ra;
        rst          = 1'b1;
        div_en       = 1'b0;
        div_ratio    = 8'd0;
        div_load_req = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        runCycles(12, 1'b1);

        requestLoad(8'd5, 1'b1);
        runCycles(15, 1'b1);

        requestLoad(8'd0, 1'b1);
        runCycles(6, 1'b1);
        requestLoad(8'd1, 1'b1);
        runCycles(6, 1'b1);

        requestLoad(8'd6, 1'b1);
        runToPeriodStart(1'b1);
        runCycles(10, 1'b0);
        runCycles(8, 1'b1);
        runCycles(2, 1'b0);
        runCycles(10, 1'b1);

        runToPeriodStart(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        runCycles(10, 1'b1);

        runCycles(8, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd7);
        runCycles(14, 1'b1);
        requestLoad(8'd3, 1'b1);
        runCycles(9, 1'b1);
        runCycles(5, 1'b0);

        en       = 1'b1;
        req      = 1'b0;
        dropNext = 1'b0;
        ra       = 8'd4;
        for (int i = 0; i < 3000; i++) begin
            if (dropNext) begin
                req      = 1'b0;
                dropNext = 1'b0;
            end
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) en = !en;
            if (!req && $urandom_range(0, 7) == 0) begin
                req = 1'b1;
                ra  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(100, 255))
                                                   : 8'($urandom_range(0, 12));
            end
            applyStimulus(rr, en, req, ra);
            if (req && lastAck) begin
                if ($urandom_range(0, 1) == 0) req = 1'b0;
                else dropNext = 1'b1;
            end
        end

        repeat (2) @(posedge clk_in);
        #3;
        if (sbQ.size() != 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboardDrain actual=%0d required=0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
